stream_framer: RTL



---
 rtl/stream_framer_if.sv | 32 +++
 rtl/stream_framer.sv | 118 +++++++++++
 2 files changed

// File: rtl/stream_framer_if.sv
// Signal bundle between stream_framer and its client: frame request, payload words, framed output.
// Valid/ready: a word or frame moves on a rising edge where valid and ready are both high;
// the source holds data stable while valid is high and ready is low.
interface stream_framer_if #(
   parameter int BLOCK_W = 512,
   parameter int TS_W    = 32,
   parameter int LEN_W   = 9,
   parameter int WORD_W  = 32
);
   logic               start;
   logic [TS_W-1:0]    timestamp;
   logic [LEN_W-1:0]   length;
   logic               in_valid;
   logic [WORD_W-1:0]  in_data;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] framed_message;
   logic [BLOCK_W-1:0] modified_framed_message;
   logic               busy;
   logic               len_err;

   modport master (
      output start, timestamp, length, in_valid, in_data, out_ready,
      input  in_ready, out_valid, framed_message, modified_framed_message, busy, len_err
   );

   modport slave (
      input  start, timestamp, length, in_valid, in_data, out_ready,
      output in_ready, out_valid, framed_message, modified_framed_message, busy, len_err
   );
endinterface

// File: rtl/stream_framer.sv
// Packs {timestamp, length, MSB-first payload} into one registered block and a modified
// copy for authentication, with word-level valid/ready in and frame-level valid/ready out.
module stream_framer #(
   parameter int BLOCK_W  = 512,
   parameter int TS_W     = 32,
   parameter int LEN_W    = 9,
   parameter int WORD_W   = 32,
   parameter int MOD_MODE = 0
) (
   input  logic           clk,
   input  logic           reset,
   stream_framer_if.slave bus,
   output logic [1:0]     state_o
);
   localparam int MSG_W      = BLOCK_W - TS_W - LEN_W;
   localparam int NWORDS_MAX = (MSG_W + WORD_W - 1) / WORD_W;
   localparam int CNT_W      = $clog2(NWORDS_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      OUT  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MSG_W-1:0]   payload_q, payload_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] framed_q, framed_d;
   logic [BLOCK_W-1:0] mod_q, mod_d;
   logic               len_err_q, len_err_d;
   logic               len_ok, word_acc, last_word;
   logic [MSG_W-1:0]   len_mask;

   assign len_ok    = int'(bus.length) <= MSG_W;
   assign word_acc  = (state_q == LOAD) && bus.in_valid;
   assign last_word = ((int'(cnt_q) + 1) * WORD_W) >= int'(len_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         len_q     <= '0;
         payload_q <= '0;
         cnt_q     <= '0;
         framed_q  <= '0;
         mod_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_d;
         len_q     <= len_d;
         payload_q <= payload_d;
         cnt_q     <= cnt_d;
         framed_q  <= framed_d;
         mod_q     <= mod_d;
         len_err_q <= len_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start && len_ok) state_d = (bus.length == '0) ? OUT : LOAD;
         LOAD: if (word_acc && last_word) state_d = OUT;
         OUT:  if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == LOAD);
      bus.out_valid = (state_q == OUT);
      bus.busy      = (state_q != IDLE);
   end

   always_comb begin
      ts_d      = ts_q;
      len_d     = len_q;
      payload_d = payload_q;
      cnt_d     = cnt_q;
      framed_d  = framed_q;
      mod_d     = mod_q;
      len_err_d = 1'b0;
      len_mask  = '0;
      if (state_q == IDLE && bus.start) begin
         if (len_ok) begin
            ts_d      = bus.timestamp;
            len_d     = bus.length;
            payload_d = '0;
            cnt_d     = '0;
         end else begin
            len_err_d = 1'b1;
         end
      end
      // Word k lands below the k earlier words; bits shifted past payload bit 0 fall off the cast.
      if (word_acc) begin
         payload_d = payload_q |
                     MSG_W'({bus.in_data, MSG_W'(0)} >> ((int'(cnt_q) + 1) * WORD_W));
         cnt_d     = cnt_q + CNT_W'(1);
      end
      if (state_d == OUT && state_q != OUT) begin
         len_mask = ~({MSG_W{1'b1}} >> len_d);
         framed_d = {ts_d, len_d, payload_d & len_mask};
         if (MOD_MODE == 0) begin
            mod_d = framed_d + BLOCK_W'(1);
         end else begin
            mod_d = {framed_d[BLOCK_W-1 -: TS_W] + TS_W'(1), framed_d[BLOCK_W-TS_W-1:0]};
         end
      end
   end

   assign bus.framed_message          = framed_q;
   assign bus.modified_framed_message = mod_q;
   assign bus.len_err                 = len_err_q;
   assign state_o                     = state_q;
endmodule
